// File: rtl/dla_platform_hw_timer_ctrl_pkg.sv
// Shared types for the platform hardware timer controller: FSM states and
// the width helper for requester indices.
package dla_platform_hw_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_STOP   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dla_platform_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr wins,
// returned both one-hot and as an index.
module dla_platform_rr_arbiter
    import dla_platform_hw_timer_ctrl_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand [N];

    // cand[k] is the k-th requester in search order, rotated by ptr.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = IW'((int'(ptr) + gi) % N);
    end

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[cand[i]]) begin
                valid           = 1'b1;
                idx             = cand[i];
                grant[cand[i]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dla_platform_hw_timer_ctrl.sv
// Round-robin owner of the shared CoreDLA hardware timer: sequences start/stop
// and returns the frozen count. Define DLA_HW_TIMER_CTRL_TIMEOUT_EN for the watchdog.
module dla_platform_hw_timer_ctrl
    import dla_platform_hw_timer_ctrl_pkg::*;
#(
    parameter int              NUM_REQ       = 2,
    parameter int              COUNTER_WIDTH = 32,
    parameter longint unsigned MAX_CYCLES    = 64'h8000_0000
) (
    input  logic                             clk,
    input  logic                             i_sclrn,
    input  logic [NUM_REQ-1:0]               i_req,
    output logic [NUM_REQ-1:0]               o_grant,
    output logic                             o_busy,
    output logic                             o_timer_start,
    output logic                             o_timer_stop,
    input  logic [COUNTER_WIDTH-1:0]         i_timer_counter,
    output logic                             o_rsp_valid,
    input  logic                             i_rsp_ready,
    output logic [id_width(NUM_REQ)-1:0]     o_rsp_id,
    output logic [COUNTER_WIDTH-1:0]         o_rsp_count,
    output logic                             o_rsp_timeout
);

    localparam int IW = id_width(NUM_REQ);

    if (NUM_REQ < 1 || NUM_REQ > 16 || MAX_CYCLES < 2 ||
        (COUNTER_WIDTH < 64 && MAX_CYCLES >= (64'd1 << COUNTER_WIDTH))) begin : g_bad_params
        $error("dla_platform_hw_timer_ctrl: parameter out of range");
    end

    state_t                   state_reg, state_next;
    logic [NUM_REQ-1:0]       grant_reg, grant_next;
    logic [IW-1:0]            owner_reg, owner_next;
    logic [IW-1:0]            rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]            rsp_id_reg, rsp_id_next;
    logic [COUNTER_WIDTH-1:0] rsp_count_reg, rsp_count_next;

    logic [NUM_REQ-1:0]       arb_grant;
    logic [IW-1:0]            arb_idx;
    logic                     arb_valid;
    logic                     owner_req;
    logic                     wd_hit;

    dla_platform_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (i_req),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign owner_req = |(i_req & grant_reg);

    always_ff @(posedge clk) begin
        if (!i_sclrn) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            rsp_id_reg    <= '0;
            rsp_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_count_reg <= rsp_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_count_next = rsp_count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_next = arb_grant;
                    owner_next = arb_idx;
                    state_next = ST_START;
                end
            end
            ST_START:  state_next = ST_RUN;
            ST_RUN: begin
                if (!owner_req || wd_hit) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP:   state_next = ST_SETTLE;
            ST_SETTLE: begin
                // Timer saw its stop pulse last cycle, so the count is frozen here.
                rsp_count_next = i_timer_counter;
                rsp_id_next    = owner_reg;
                state_next     = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    grant_next  = '0;
                    rr_ptr_next = (owner_reg == IW'(NUM_REQ - 1)) ? '0 : owner_reg + IW'(1);
                    state_next  = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

`ifdef DLA_HW_TIMER_CTRL_TIMEOUT_EN
    logic [COUNTER_WIDTH-1:0] wd_reg;
    logic                     timeout_reg;
    logic                     rsp_timeout_reg;

    // wd_reg holds the RUN cycles already completed; this cycle's increment
    // brings it to MAX_CYCLES-1, which ends the window.
    assign wd_hit = (state_reg == ST_RUN) && (wd_reg == COUNTER_WIDTH'(MAX_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (!i_sclrn) begin
            wd_reg          <= '0;
            timeout_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            if (state_reg == ST_START) begin
                wd_reg      <= '0;
                timeout_reg <= 1'b0;
            end else if (state_reg == ST_RUN) begin
                wd_reg <= wd_reg + COUNTER_WIDTH'(1);
                if (wd_hit) begin
                    timeout_reg <= 1'b1;
                end
            end
            if (state_reg == ST_SETTLE) begin
                rsp_timeout_reg <= timeout_reg;
            end
        end
    end

    assign o_rsp_timeout = rsp_timeout_reg;
`else
    assign wd_hit        = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    assign o_grant       = grant_reg;
    assign o_busy        = (state_reg != ST_IDLE);
    assign o_timer_start = (state_reg == ST_START);
    assign o_timer_stop  = (state_reg == ST_STOP);
    assign o_rsp_valid   = (state_reg == ST_RESP);
    assign o_rsp_id      = rsp_id_reg;
    assign o_rsp_count   = rsp_count_reg;

endmodule

// File: doc/dla_platform_hw_timer_ctrl.md
# dla_platform_hw_timer_ctrl

Shares one CoreDLA platform hardware timer between `NUM_REQ` requesters (host CSR path, debug/profiling agents). Grants the timer round-robin and sequences its start and stop pulses. Captures the final count and returns it to the owning requester over a valid/ready response channel. Sits in the CoreDLA IP clock domain beside the timer instance and drives the timer's `i_start`/`i_stop` and reads its `o_counter`.

## Interface
- `NUM_REQ`, 2: number of requesters; range 1–16.
- `COUNTER_WIDTH`, 32: width of the timer counter and of the response count.
- `MAX_CYCLES`, 2**31: timeout window. Used only with `DLA_HW_TIMER_CTRL_TIMEOUT_EN`. Must be less than 2**COUNTER_WIDTH.
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `i_sclrn`  in  1  synchronous active-low reset.
- `i_req`  in  NUM_REQ  level per requester. High means it wants or holds the timer. Dropping it while owner means stop.
- `o_grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `o_busy`  out  1  high in every state except IDLE.
- `o_timer_start`  out  1  one-cycle pulse to the timer `i_start`.
- `o_timer_stop`  out  1  one-cycle pulse to the timer `i_stop`.
- `i_timer_counter`  in  COUNTER_WIDTH  timer `o_counter`.
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response accept.
- `o_rsp_id`  out  $clog2(NUM_REQ) (min 1)  index of the owner the response belongs to.
- `o_rsp_count`  out  COUNTER_WIDTH  captured count.
- `o_rsp_timeout`  out  1  high when the window ended by timeout.

## Operation
- FSM states: IDLE, START, RUN, STOP, SETTLE, RESP.
- IDLE
  - If any `i_req` bit is set, pick a winner round-robin, starting the search at pointer `rr_ptr`.
  - Register the winner into `o_grant` and go to START.
- START: assert `o_timer_start` for exactly this cycle, then go to RUN.
- RUN
  - When the owner's `i_req` is sampled low, go to STOP.
  - `i_req` of non-owners is ignored.
  - An owner drop during START is seen on the first RUN cycle.
- STOP: assert `o_timer_stop` for exactly this cycle, then go to SETTLE.
- SETTLE: the timer counter is now frozen. Register `o_rsp_count` from `i_timer_counter` and `o_rsp_id` from the owner, then go to RESP.
- RESP
  - Hold `o_rsp_valid` high with `o_rsp_id`, `o_rsp_count` and `o_rsp_timeout` stable until `i_rsp_ready` is high.
  - On the accepting cycle: clear `o_grant`, set `rr_ptr` to (owner+1) mod NUM_REQ, and go to IDLE.
- `o_grant` stays asserted from START through RESP.
- A requester that re-raises `i_req` during its own RESP competes again only from IDLE.
- `i_rsp_ready` outside RESP is ignored.
- Count rule: `o_rsp_count` = number of cycles from the START cycle to the STOP cycle, exclusive of START.
  - The timer wraps modulo 2**COUNTER_WIDTH; wrap is not detected.
- Reset forces IDLE and `rr_ptr`=0.
  - The timer shares this reset, so no stop pulse is issued.
  - A reset in mid-measurement discards the measurement with no response.

## Timing
- Reset value 0 for every output: `o_grant`, `o_busy`, `o_timer_start`, `o_timer_stop`, `o_rsp_valid`, `o_rsp_id`, `o_rsp_count`, `o_rsp_timeout`.
- Request in IDLE at cycle T gives START (grant and start pulse) at T+1 and RUN from T+2.
- Owner drop sampled at RUN cycle R gives STOP at R+1, SETTLE at R+2 and `o_rsp_valid` at R+3.
- Minimum turnaround is IDLE→IDLE in 6 cycles when `i_rsp_ready` is tied high.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `DLA_HW_TIMER_CTRL_TIMEOUT_EN` defined
  - A watchdog counter clears in START and increments in RUN.
  - When it reaches `MAX_CYCLES`-1, RUN goes to STOP regardless of `i_req`, and `o_rsp_timeout`=1 for that response.
- Undefined: no watchdog logic, and `o_rsp_timeout` is tied to 0.

## Structure
- Package `dla_platform_hw_timer_ctrl_pkg` holds the FSM state enum and the id-width function (max(1,$clog2(n))).
- Sub-module `dla_platform_rr_arbiter` is a combinational round-robin pick.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - It is reusable elsewhere in the platform.

## Test plan
- Single requester, drop `i_req` 100 cycles after grant → start pulse at T+1, response count 100+1 per the count rule (verify against timer model), `o_rsp_id`=0.
- `i_req`=2'b11 from reset → owner 0 served first, then owner 1. Pointer after each response is owner+1.
- Hold `i_rsp_ready` low for 20 cycles in RESP → `o_rsp_valid` and data stay stable, no new grant, and a competing `i_req` waits.
- Assert `i_sclrn`=0 during RUN → all outputs 0 next cycle, no response, and a fresh request restarts cleanly.
- With `TIMEOUT_EN` and `MAX_CYCLES`=16, hold `i_req` high → auto-stop, `o_rsp_timeout`=1, count 16. Without the macro: no stop, and the response only follows the owner drop.
